// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial N-bit adder, one full-adder slice plus a carry flop
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Counter value on the cycle the MSB pair is at the bottom of the shifters.
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ss_q, ss_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_q, c_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_s;
  logic             fa_c;

  // Single full-adder slice fed by the operand LSBs and the carry flop.
  always_comb begin
    fa_s = sa_q[0] ^ sb_q[0] ^ c_q;
    fa_c = (sa_q[0] & sb_q[0]) | (sa_q[0] & c_q) | (sb_q[0] & c_q);
  end

  // Next-state and datapath update; everything holds unless the state says otherwise.
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    ss_d    = ss_q;
    sum_d   = sum_q;
    c_d     = c_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          c_d     = cin;
          ss_d    = '0;
          cnt_d   = '0;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        c_d   = fa_c;
        ss_d  = {fa_s, ss_q[WIDTH-1:1]};
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // Last bit: publish the fully shifted sum and the final carry together.
          sum_d   = {fa_s, ss_q[WIDTH-1:1]};
          cout_d  = fa_c;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously so an abort leaves no stale result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ss_q    <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ss_q    <= ss_d;
      sum_q   <= sum_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Status is decoded purely from the registered state.
  always_comb begin
    busy = (state_q == S_ADD);
    done = (state_q == S_DONE);
    sum  = sum_q;
    cout = cout_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - self-checking bench for serial_adder (WIDTH 8 and 16)
module tb_serial_adder;

  localparam int W8  = 8;
  localparam int W16 = 16;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        cin8;
  logic        busy8, done8;
  logic [7:0]  sum8;
  logic        cout8;

  logic        start16;
  logic [15:0] a16, b16;
  logic        cin16;
  logic        busy16, done16;
  logic [15:0] sum16;
  logic        cout16;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  serial_adder #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
  );

  serial_adder #(.WIDTH(W16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model for the 8-bit instance: an accepted op is busy for WIDTH cycles,
  // then done for one, then one more cycle before a new start can be taken.
  int         m_age = -1;
  logic [8:0] m_pend = '0;
  logic [8:0] m_res = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_age <= -1;
      m_res <= '0;
    end else if (m_age < 0) begin
      if (start8) begin
        m_age  <= 0;
        m_pend <= 9'(a8) + 9'(b8) + 9'(cin8);
      end
    end else if (m_age == W8) begin
      m_age <= -1;
    end else begin
      m_age <= m_age + 1;
      if (m_age + 1 == W8) m_res <= m_pend;
    end
  end

  logic       e_busy, e_done;
  logic [8:0] e_res;
  int         dcount = 0;
  int         last_done = -1;
  int         last_gap = 0;
  bit         ok;
  int         d0;
  int         seen;
  int         prev16;
  logic [8:0]  r9;
  logic [16:0] r17;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_done8(output bit found);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done8) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [8:0] exp, input string name);
    bit f;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    step();
    start8 = 1'b0;
    wait_done8(f);
    chk({name, "_timeout"}, 32'(f), 32'd1);
    if (f) chk(name, 32'({cout8, sum8}), 32'(exp));
    step();
  endtask

  initial begin
    rst_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;

    // Per-cycle compare against the model, plus done-pulse bookkeeping.
    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          e_busy = 1'b0; e_done = 1'b0; e_res = '0;
          last_done = -1;
        end else begin
          e_busy = (m_age >= 0 && m_age < W8);
          e_done = (m_age == W8);
          e_res  = m_res;
        end
        chk("busy8", 32'(busy8), 32'(e_busy));
        chk("done8", 32'(done8), 32'(e_done));
        chk("result8", 32'({cout8, sum8}), 32'(e_res));
        if (rst_n && done8) begin
          dcount++;
          if (last_done >= 0) begin
            last_gap = cyc - last_done;
            chk("spacing8", 32'(last_gap >= W8 + 2), 32'd1);
          end
          last_done = cyc;
        end
      end
    join_none

    step(); step();
    chk("reset_busy8", 32'(busy8), 32'd0);
    chk("reset_done8", 32'(done8), 32'd0);
    chk("reset_sum8", 32'({cout8, sum8}), 32'd0);
    chk("reset_busy16", 32'(busy16), 32'd0);
    chk("reset_sum16", 32'({cout16, sum16}), 32'd0);
    rst_n = 1'b1;
    step();

    // Basic op: 0x35 + 0x4A = 0x7F.
    op8(8'h35, 8'h4A, 1'b0, 9'h07F, "add_35_4a");
    chk("model_pin_7f", 32'(m_res), 32'h07F);

    // Full carry ripple and all-ones with carry-in.
    op8(8'hFF, 8'h01, 1'b0, 9'h100, "add_ff_01");
    op8(8'hFF, 8'hFF, 1'b1, 9'h1FF, "add_ff_ff_c");
    chk("model_pin_1ff", 32'(m_res), 32'h1FF);

    // Operands change right after acceptance; captured values must be used.
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b1;
    wait_done8(ok);
    chk("capture_timeout", 32'(ok), 32'd1);
    chk("capture_sum", 32'({cout8, sum8}), 32'h030);
    step();

    // start during ADD and during DONE is ignored.
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; start8 = 1'b1;
    d0 = dcount;
    step();
    start8 = 1'b0;
    step(); step();
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    wait_done8(ok);
    chk("ignore_timeout", 32'(ok), 32'd1);
    chk("ignore_sum", 32'({cout8, sum8}), 32'h046);
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step();
    chk("ignore_one_done", 32'(dcount - d0), 32'd1);
    chk("ignore_idle", 32'(busy8), 32'd0);

    // start held high: re-accepted every WIDTH+2 cycles.
    a8 = 8'h01; b8 = 8'h02; cin8 = 1'b0; start8 = 1'b1;
    seen = 0;
    for (int i = 0; i < 60 && seen < 3; i++) begin
      step();
      if (done8) seen++;
    end
    start8 = 1'b0;
    chk("held_three_dones", 32'(seen), 32'd3);
    step();
    chk("held_gap", 32'(last_gap), 32'(W8 + 2));
    chk("held_sum", 32'({cout8, sum8}), 32'h003);
    step(); step();

    // Asynchronous reset in the middle of an operation.
    a8 = 8'hC3; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    d0 = dcount;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_sum", 32'({cout8, sum8}), 32'd0);
    step(); step(); step();
    rst_n = 1'b1;
    step();
    chk("abort_no_done", 32'(dcount - d0), 32'd0);
    op8(8'h01, 8'h01, 1'b1, 9'h003, "after_reset");

    // Random regression, 8-bit.
    for (int i = 0; i < 500; i++) begin
      logic [7:0] ra, rb;
      logic       rc;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      r9 = 9'(ra) + 9'(rb) + 9'(rc);
      op8(ra, rb, rc, r9, "rand8");
    end

    // Random regression, 16-bit.
    prev16 = -1;
    for (int i = 0; i < 500; i++) begin
      a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
      r17 = 17'(a16) + 17'(b16) + 17'(cin16);
      start16 = 1'b1;
      step();
      start16 = 1'b0;
      a16 = ~a16; b16 = 16'($urandom); cin16 = ~cin16;
      ok = 1'b0;
      for (int j = 0; j < 40; j++) begin
        if (done16) begin
          ok = 1'b1;
          break;
        end
        step();
      end
      chk("rand16_timeout", 32'(ok), 32'd1);
      if (ok) begin
        chk("rand16", 32'({cout16, sum16}), 32'(r17));
        if (prev16 >= 0) chk("spacing16", 32'(cyc - prev16 >= W16 + 2), 32'd1);
        prev16 = cyc;
      end
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial N-bit adder: the sequential counterpart to the team's combinational subtractor cells.
- Loads two operands and a carry-in, then adds one bit per clock, LSB first, through a single full-adder slice and a carry flip-flop.
- Registers the result and pulses done when finished.
- Used as a small-area arithmetic unit and as the reference datapath for subtract/add cross-checking benches.

Parameters:
- WIDTH, 8, operand and sum width in bits (must be >= 2).
- CW, $clog2(WIDTH+1), bit-counter width (derived; do not override).

Ports:
- clk    input   1      rising-edge clock
- rst_n  input   1      asynchronous active-low reset
- start  input   1      request; sampled only in IDLE
- a      input   WIDTH  operand A; captured when start is accepted
- b      input   WIDTH  operand B; captured when start is accepted
- cin    input   1      carry-in; captured when start is accepted
- busy   output  1      high while in ADD
- done   output  1      one-cycle pulse; sum/cout valid from this cycle on
- sum    output  WIDTH  registered result (a+b+cin) mod 2^WIDTH
- cout   output  1      registered carry-out of the MSB

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal shift registers, carry FF and counter are cleared.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - On a clk edge with start=1: load SA<=a, SB<=b, C<=cin, cnt<=0, SS<=0, then go to ADD.
  - With start=0: stay in IDLE.
- ADD, on each edge:
  - s = SA[0]^SB[0]^C.
  - C <= (SA[0]&SB[0]) | (SA[0]&C) | (SB[0]&C).
  - SS <= {s, SS[WIDTH-1:1]}.
  - SA, SB shift right by one with zero fill.
  - cnt <= cnt+1.
- ADD to DONE: on the edge where cnt==WIDTH-1, the last bit is processed. On that same edge, sum <= {s, SS[WIDTH-1:1]}, cout <= the new carry, and state <= DONE.
- DONE: done=1 for exactly one cycle. The next edge returns to IDLE unconditionally.
- Latency: start accepted at edge E0. busy is high from E0 to E(WIDTH). done is high from E(WIDTH) to E(WIDTH+1). Total is WIDTH+1 cycles from acceptance to the done pulse.
- Output timing: busy and done are decoded from registered state, with no combinational path from inputs. sum and cout change only on the completion edge and hold until the next completion or reset.
- start during ADD or DONE is ignored and not queued. The earliest next acceptance is the edge after done (first cycle in IDLE).
- a, b and cin may change freely after acceptance. Only the values captured at E0 are used.
- Arithmetic: the result equals the low WIDTH bits of a+b+cin. cout is bit WIDTH of that sum. All unsigned; there is no overflow flag.
- Reset asserted mid-operation:
  - Immediately: busy=0, done=0, sum=0, cout=0, state=IDLE.
  - The partial result is discarded and no done pulse occurs.
  - After rst_n deasserts, the first start edge is accepted normally.
- start held high continuously: a new operation is accepted on each IDLE visit, i.e. every WIDTH+2 cycles.

Test Plan:
- a=8'h35, b=8'h4A, cin=0, start pulsed at E0 -> busy high E0..E8, done pulse E8..E9, sum=8'h7F, cout=0.
- a=8'hFF, b=8'h01, cin=0 -> carry ripples through all bits, sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Operands changed to 8'hAA/8'h55 on the cycle after acceptance of a=8'h10, b=8'h20 -> sum=8'h30, cout=0, i.e. the captured values are used.
- start re-pulsed during ADD (cycle 3) and during DONE -> ignored, exactly one done pulse. start held high -> accepts again at E(WIDTH+2) = E10.
- rst_n driven low at cycle 4 of a=8'hC3, b=8'h3C -> busy, done, sum and cout go to 0 asynchronously, with no done pulse. After release, a=8'h01, b=8'h01, cin=1 -> sum=8'h03.
- Random regression with WIDTH=8 and WIDTH=16, 500 ops each -> {cout,sum} == a+b+cin every time, done spacing >= WIDTH+2 cycles.
